fifo_flags: RTL and testbench
=============================

# fifo_flags

Parametrised synchronous FIFO for the bexkat1 datapath. It succeeds the fixed 16-entry buffer with three changes: it holds a true 2**AWIDTH entries, it exports an occupancy count with programmable almost-full and almost-empty thresholds, and it adds a synchronous flush plus sticky overflow/underflow error flags. It sits between bus masters and peripherals (UART, SD, video command queues) that need back-pressure with advance warning.

## Interface
- AWIDTH, 4: address width; DEPTH = 2**AWIDTH entries (must be ≥ 2).
- DWIDTH, 32: data width.
- AFULL_LVL, 2**AWIDTH-2: almost_full asserts when count ≥ AFULL_LVL (1..DEPTH).
- AEMPTY_LVL, 1: almost_empty asserts when count ≤ AEMPTY_LVL (0..DEPTH-1).

Ports:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers and count.
- push  in  1  write request.
- pop  in  1  read request.
- in  in  DWIDTH  write data.
- out  out  DWIDTH  head-of-queue data (show-ahead).
- count  out  AWIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_LVL.
- almost_empty  out  1  count ≤ AEMPTY_LVL.
- overflow  out  1  sticky; set by push while full and no pop.
- underflow  out  1  sticky; set by pop while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

## Operation
- Storage: DEPTH × DWIDTH register array. Read pointer ridx and write pointer widx are each AWIDTH bits and wrap modulo DEPTH. count is a separate AWIDTH+1-bit register.
- wr_ok = push && (!full || pop). rd_ok = pop && !empty.
- On wr_ok: mem[widx] ← in, widx += 1. On rd_ok: ridx += 1.
- count: wr_ok and rd_ok together → unchanged. wr_ok only → +1. rd_ok only → −1.
- Full with push and pop in the same cycle: both are accepted, the head is consumed, the new word is written at widx (== ridx before the update), and count stays at DEPTH.
- Empty with push and pop in the same cycle: the push is accepted, the pop is rejected and sets underflow, and count becomes 1. There is no bypass path.
- Error flags: overflow ← 1 when push && full && !pop. underflow ← 1 when pop && empty. err_clr clears both. If err_clr and a new error occur in the same cycle, set wins.
- flush: ridx, widx and count ← 0 next cycle, and all push/pop in that cycle are ignored. Memory contents are not cleared. Flush does not clear the error flags, and errors cannot be raised in a flush cycle.
- out = mem[ridx], combinational from the registers. It is valid only while !empty. While empty it shows a stale word.
- All flags are combinational decodes of count.

## Timing
- Reset (rst_ni low, asynchronous): ridx = widx = count = 0, and all memory words = 0. Resulting outputs: out = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AFULL_LVL ≥ 1), overflow = underflow = 0. Release is synchronous to clk_i by upstream convention.
- Write-to-read latency: a word pushed at edge N appears on out after edge N when the FIFO was empty, so empty deasserts in the same cycle.
- count and the flags update one edge after the accepted push/pop. There is no combinational path from push/pop to any output.
- Pop acknowledges the current out value. The next word appears after the edge.
- Reset asserted mid-operation: all state returns to the reset values immediately, regardless of clk_i.
- Pointer wrap: after DEPTH pushes and DEPTH pops, ridx == widx == 0 again with no glitch on empty/full. count alone disambiguates full from empty.

## Test plan
- Reset/fill/drain (AWIDTH=4): after reset out=0, empty=1. Push 0x1..0x10 → full=1 and count=16 after the 16th edge, almost_full from count=14. Pop 16× → out sequence 0x1..0x10, then empty=1.
- Full simultaneous: with 16 entries held, push 0xAA and pop in one cycle → count stays 16, out advances. After 15 more pops the last word read is 0xAA. overflow stays 0.
- Errors: push while full (no pop) → count unchanged, overflow=1 next cycle. Pop while empty → underflow=1. err_clr → both 0. err_clr with a concurrent empty pop → underflow stays 1.
- Empty simultaneous: with the FIFO empty, push 0x55 and pop in one cycle → count=1, out=0x55, underflow=1.
- Flush: with 5 entries, assert flush with push → count=0, empty=1, and the push is discarded. A following push of 0x77 gives out=0x77.
- Wrap and async reset: run 40 random push/pops against a reference queue model, checking out, count and flags every cycle. Drop rst_ni between clock edges → count=0 and empty=1 immediately.

Source files
------------

// File: rtl/fifo_flags.sv
// fifo_flags: parametrised synchronous FIFO with an occupancy count,
// programmable almost-full/almost-empty thresholds, a synchronous flush,
// and sticky overflow/underflow error flags.
// The output is show-ahead: out always presents mem[ridx] with no read latency.
module fifo_flags #(
    parameter int AWIDTH     = 4,
    parameter int DWIDTH     = 32,
    parameter int AFULL_LVL  = 2**AWIDTH - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] in,
    output logic [DWIDTH-1:0] out,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int DEPTH = 2**AWIDTH;

    // Thresholds resized to the count width so the flag decodes compare like widths.
    localparam logic [AWIDTH:0] C_DEPTH  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] C_AFULL  = (AWIDTH+1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] C_AEMPTY = (AWIDTH+1)'(AEMPTY_LVL);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH-1:0] r_ridx;
    logic [AWIDTH-1:0] r_widx;
    logic [AWIDTH:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_ovf_set;
    logic w_udf_set;

    // Status decodes come only from registered state, so push/pop never reach an output.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Accept decisions; a flush cycle swallows every request and cannot raise an error.
    // A push into a full FIFO is still accepted when a pop frees the head in the same cycle.
    always_comb begin
        w_wr_ok   = 1'b0;
        w_rd_ok   = 1'b0;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (!flush) begin
            w_wr_ok   = push && (!w_full || pop);
            w_rd_ok   = pop && !w_empty;
            w_ovf_set = push && w_full && !pop;
            w_udf_set = pop && w_empty;
        end
    end

    // Storage array: cleared on reset so out reads zero before the first write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[r_widx] <= in;
        end
    end

    // Read/write pointers wrap naturally modulo DEPTH; flush returns both to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ridx <= '0;
            r_widx <= '0;
        end else if (flush) begin
            r_ridx <= '0;
            r_widx <= '0;
        end else begin
            if (w_wr_ok) begin
                r_widx <= r_widx + AWIDTH'(1);
            end
            if (w_rd_ok) begin
                r_ridx <= r_ridx + AWIDTH'(1);
            end
        end
    end

    // Occupancy count: separate register so full and empty stay distinct when pointers match.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_wr_ok && !w_rd_ok) begin
            r_count <= r_count + (AWIDTH+1)'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            r_count <= r_count - (AWIDTH+1)'(1);
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !err_clr) || w_ovf_set;
            r_underflow <= (r_underflow && !err_clr) || w_udf_set;
        end
    end

    assign out          = r_mem[r_ridx];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed checks of fill/drain, simultaneous push/pop at the
// full and empty boundaries, error flags, flush, a short random run against a
// queue model, and asynchronous reset.
module tb_fifo_flags;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk_i;
    logic          rst_ni;
    logic          flush;
    logic          push;
    logic          pop;
    logic [DW-1:0] in;
    logic [DW-1:0] out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state for the random phase.
    logic [31:0] q[$];
    logic        m_ovf;
    logic        m_udf;

    fifo_flags #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .AFULL_LVL (14),
        .AEMPTY_LVL(1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush       (flush),
        .push        (push),
        .pop         (pop),
        .in          (in),
        .out         (out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; the model advances alongside, outputs are sampled 1ns after the edge.
    task automatic cyc(input logic p, input logic r, input logic f, input logic ec, input logic [31:0] d);
        logic wr;
        logic rd;
        logic oset;
        logic uset;
        push    = p;
        pop     = r;
        flush   = f;
        err_clr = ec;
        in      = d;
        wr   = !f && p && (q.size() < DEPTH || r);
        rd   = !f && r && (q.size() > 0);
        oset = !f && p && (q.size() == DEPTH) && !r;
        uset = !f && r && (q.size() == 0);
        if (f) begin
            q.delete();
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        m_ovf = (m_ovf && !ec) || oset;
        m_udf = (m_udf && !ec) || uset;
        @(posedge clk_i);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        in      = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        #12;
        // Reset state
        check("rst_out",   out, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        check("rst_ae",    32'(almost_empty), 32'd1);
        check("rst_af",    32'(almost_full), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_udf",   32'(underflow), 32'd0);
        rst_ni = 1'b1;
        #4;

        // Fill with 1..16
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
            check("fill_count", 32'(count), 32'(i));
            check("fill_af",    32'(almost_full), 32'(i >= 14));
            check("fill_ae",    32'(almost_empty), 32'(i <= 1));
            check("fill_full",  32'(full), 32'(i == DEPTH));
            check("fill_head",  out, 32'h1);
        end
        // Drain, checking show-ahead order
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_out", out, 32'(i));
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(i + 32'h100));
        check("fs_full", 32'(full), 32'd1);
        check("fs_head0", out, 32'h101);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'hAA);
        check("fs_count", 32'(count), 32'd16);
        check("fs_head1", out, 32'h102);
        check("fs_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("fs_last", out, 32'hAA);
        check("fs_cnt1", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("fs_empty", 32'(empty), 32'd1);

        // Overflow: push while full without pop
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", out, 32'h1);
        // Flush does not clear errors
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("ovf_keep", 32'(overflow), 32'd1);
        check("fl_empty", 32'(empty), 32'd1);
        // Underflow: pop while empty
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_udf", 32'(underflow), 32'd0);
        // err_clr with concurrent empty pop: set wins
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        check("clrset_udf", 32'(underflow), 32'd1);
        check("clrset_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("clr2_udf", 32'(underflow), 32'd0);

        // Empty with simultaneous push and pop
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
        check("es_count", 32'(count), 32'd1);
        check("es_out", out, 32'h55);
        check("es_udf", 32'(underflow), 32'd1);
        check("es_empty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        check("es_drain", 32'(empty), 32'd1);

        // Flush with a concurrent push
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(i + 32'h40));
        check("pf_count", 32'(count), 32'd5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h99);
        check("fl_count", 32'(count), 32'd0);
        check("fl_empty2", 32'(empty), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h77);
        check("fl_out", out, 32'h77);
        check("fl_cnt1", 32'(count), 32'd1);
        check("fl_udf", 32'(underflow), 32'd0);

        // Random run against the queue model (pointers are not at zero here, so they wrap)
        for (int i = 0; i < 40; i++) begin
            logic p;
            logic r;
            p = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 4);
            cyc(p, r, 1'b0, 1'b0, $urandom);
            check("rnd_count", 32'(count), 32'(q.size()));
            check("rnd_empty", 32'(empty), 32'(q.size() == 0));
            check("rnd_full",  32'(full), 32'(q.size() == DEPTH));
            check("rnd_af",    32'(almost_full), 32'(q.size() >= 14));
            check("rnd_ae",    32'(almost_empty), 32'(q.size() <= 1));
            check("rnd_ovf",   32'(overflow), 32'(m_ovf));
            check("rnd_udf",   32'(underflow), 32'(m_udf));
            if (q.size() > 0) check("rnd_out", out, q[0]);
        end

        // Asynchronous reset between edges
        if (q.size() == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h12);
        check("ar_pre", 32'(empty), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_out",   out, 32'h0);
        check("ar_ovf",   32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
